t2c_maze_world: RTL and testbench
=================================

// Module: t2c_maze_world
// PURPOSE
//  Maze-environment responder for the MazeSolver explorer. Holds a loadable ROWSxCOLS wall map.
//  Tracks bot pose (cell + heading), consumes the explorer's 3-bit move command, returns left/mid/right
//  wall sensors for the new pose one cycle later. Flags exit reached, wall collisions, counts steps/dead ends.
//  Sits opposite the explorer in hardware co-simulation and the FPGA self-test harness.
// PARAMETERS
//  ROWS     9  maze rows (row index grows southward)
//  COLS     9  maze columns (col index grows eastward)
//  START_C  4  start column;  START_R 8  start row; start heading NORTH
//  EXIT_C   4  exit column;   EXIT_R  0  exit row
// PORTS
//  clk            in   1  clock
//  rst_n          in   1  reset, synchronous, active-low
//  start          in   1  1-cycle pulse: place bot at start pose, clear counters, enter RUN
//  wr_en          in   1  map write strobe (honoured in LOAD only)
//  wr_addr        in   7  cell index = row*COLS+col
//  wr_data        in   4  walls of cell: bit0 N, bit1 E, bit2 S, bit3 W (1 = wall)
//  move           in   3  0 STOP, 1 FORWARD, 2 LEFT, 3 RIGHT, 4 U_TURN; 5-7 treated as STOP
//  left/mid/right out  1  wall on bot's left/front/right in current cell (1 = wall)
//  pos_col,pos_row out 4  current cell
//  heading        out  2  0 N, 1 E, 2 S, 3 W
//  done           out  1  sticky: exit cell reached
//  collision      out  1  sticky: illegal advance attempted
//  step_count     out 16  cells advanced, saturating at 16'hFFFF
//  deadend_count  out  4  U_TURN commands accepted, saturating at 4'hF
// BEHAVIOUR
//  - States: LOAD, RUN, DONE, ERROR. Reset -> LOAD; pos=(START_C,START_R), heading=N, left/mid/right=0,
//    done=0, collision=0, counters=0. Map RAM is not reset.
//  - LOAD: wr_en writes wr_data to wr_addr (addr >= ROWS*COLS ignored); move ignored.
//    start -> RUN; sensors loaded from start cell. With start+wr_en in same cycle: write commits,
//    sensors use pre-write contents.
//  - RUN, move sampled at edge k; pose, sensors, counters valid after edge k (1-cycle latency, one command/cycle):
//    STOP: hold all. FORWARD: new heading = heading. LEFT: heading-1 mod 4. RIGHT: heading+1 mod 4.
//    FORWARD/LEFT/RIGHT then advance one cell in new heading; U_TURN: heading+2 mod 4, no advance,
//    deadend_count+1.
//  - Advance legal iff wall[new heading] of current cell = 0 and target in bounds. N: row-1, E: col+1,
//    S: row+1, W: col-1. Legal: update pos, step_count+1. Illegal: pose/sensors/step_count held,
//    collision=1, -> ERROR.
//  - Sensors for pose (c,r,h), w = map[r*COLS+c]: mid=w[h], left=w[(h+3)%4], right=w[(h+1)%4].
//  - Legal advance into (EXIT_C,EXIT_R): done=1 same edge, -> DONE. DONE/ERROR: moves ignored,
//    outputs frozen.
//  - start in RUN/DONE/ERROR: restart (pose to start, flags/counters cleared, map kept) -> RUN;
//    start has priority over move in the same cycle. wr_en outside LOAD ignored.
//  - rst_n low at any time, including mid-run: full reset to LOAD same edge; map contents retained.
// STRUCTURE
//  - Package t2c_maze_pkg: move codes (STOP..U_TURN), heading codes, wall bit indices, state enum,
//    shared with explorer/bench.
//  - Sub-module t2c_maze_wall_ram: ROWS*COLS x 4 map, synchronous write, asynchronous read,
//    one read port addressed by next pose.
//  - Top: state FSM, pose/heading regs, legality + next-pose logic, sensor regs, saturating counters.
// TESTING
//  1 Reset, no start: pos=(4,8), heading=0, sensors=000, done=0, collision=0, counts=0; move=1 ignored.
//  2 Load straight N corridor col 4 (cells walls E|W=4'hA, border cells closed), start, 8x FORWARD ->
//    sensors 101 each cycle, pos_row 7..0, done=1 after 8th, step_count=8, DONE; further FORWARD no-op.
//  3 Start cell walls N|E|W=4'hB, FORWARD -> collision=1, pos stays (4,8), step_count=0, ERROR;
//    then start -> RUN, collision=0.
//  4 Dead-end cell then U_TURN -> heading N->S, pos unchanged, sensors from new heading,
//    deadend_count=1; 16 U_TURNs saturate at 15.
//  5 LEFT from (4,8) heading N with W open -> heading=3, pos=(3,8) next cycle; RIGHT back -> heading=0,
//    pos=(3,7) if N open.
//  6 start and move=1 same cycle mid-run -> pose = start, move dropped; rst_n low mid-run -> LOAD,
//    map retained (re-start yields same sensors).

Source files
------------

// File: rtl/t2c_maze_pkg.sv
// Shared codes for the maze world, explorer and bench.
// Move, heading, wall-bit and FSM state encodings.
package t2c_maze_pkg;

  typedef enum logic [2:0] {
    MV_STOP  = 3'd0,
    MV_FWD   = 3'd1,
    MV_LEFT  = 3'd2,
    MV_RIGHT = 3'd3,
    MV_UTURN = 3'd4
  } move_e;

  typedef enum logic [1:0] {
    HD_N = 2'd0,
    HD_E = 2'd1,
    HD_S = 2'd2,
    HD_W = 2'd3
  } heading_e;

  localparam int WALL_N = 0;
  localparam int WALL_E = 1;
  localparam int WALL_S = 2;
  localparam int WALL_W = 3;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] col;
    logic [3:0] row;
    logic [1:0] hd;
  } pose_t;

endpackage

// File: rtl/t2c_maze_wall_ram.sv
// Wall map: ROWS*COLS x 4, sync write, async read.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
module t2c_maze_wall_ram #(
  parameter int ROWS = 9,
  parameter int COLS = 9
) (
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [3:0] wdata,
  input  logic [6:0] raddr,
  output logic [3:0] rdata
);

  localparam int CELLS = ROWS * COLS;

  logic [3:0] mem [CELLS];

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < CELLS))
      mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = 4'h0;
    if (32'(raddr) < CELLS)
      rdata = mem[raddr];
  end

endmodule

// File: rtl/t2c_maze_world.sv
// Maze environment: pose tracking, wall sensing, flags, counters.
// Ports: clk/rst_n, start, map write (wr_*), move in; sensors, pose, flags, counts out.
module t2c_maze_world
  import t2c_maze_pkg::*;
#(
  parameter int ROWS    = 9,
  parameter int COLS    = 9,
  parameter int START_C = 4,
  parameter int START_R = 8,
  parameter int EXIT_C  = 4,
  parameter int EXIT_R  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        wr_en,
  input  logic [6:0]  wr_addr,
  input  logic [3:0]  wr_data,
  input  logic [2:0]  move,
  output logic        left,
  output logic        mid,
  output logic        right,
  output logic [3:0]  pos_col,
  output logic [3:0]  pos_row,
  output logic [1:0]  heading,
  output logic        done,
  output logic        collision,
  output logic [15:0] step_count,
  output logic [3:0]  deadend_count
);

  state_e      state_q, state_d;
  pose_t       pose_q, pose_d;
  logic [3:0]  walls_q, walls_d;
  logic [2:0]  sens_q, sens_d;
  logic        done_q, done_d;
  logic        coll_q, coll_d;
  logic [15:0] steps_q, steps_d;
  logic [3:0]  dead_q, dead_d;

  logic        ram_we;
  logic [6:0]  rd_addr;
  logic [3:0]  rd_data;

  logic [1:0]  nh;
  logic        is_adv;
  logic        is_ut;
  logic        in_b;
  logic [3:0]  tc;
  logic [3:0]  tr;
  logic        legal;
  logic        load_walls;

  assign ram_we = wr_en && (state_q == ST_LOAD);

  // The read port follows the next pose; walls_q keeps the
  // current cell so legality needs no second port.
  assign rd_addr =
    7'(32'(pose_d.row) * COLS + 32'(pose_d.col));

  t2c_maze_wall_ram #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    nh     = pose_q.hd;
    is_adv = 1'b0;
    is_ut  = 1'b0;
    unique case (1'b1)
      (move == MV_FWD): begin
        is_adv = 1'b1;
      end
      (move == MV_LEFT): begin
        nh     = pose_q.hd - 2'd1;
        is_adv = 1'b1;
      end
      (move == MV_RIGHT): begin
        nh     = pose_q.hd + 2'd1;
        is_adv = 1'b1;
      end
      (move == MV_UTURN): begin
        is_ut = 1'b1;
      end
      default: begin
        nh = pose_q.hd;
      end
    endcase
  end

  always_comb begin
    tc   = pose_q.col;
    tr   = pose_q.row;
    in_b = 1'b0;
    unique case (nh)
      HD_N: begin
        in_b = pose_q.row != 4'd0;
        tr   = pose_q.row - 4'd1;
      end
      HD_E: begin
        in_b = pose_q.col != 4'(COLS - 1);
        tc   = pose_q.col + 4'd1;
      end
      HD_S: begin
        in_b = pose_q.row != 4'(ROWS - 1);
        tr   = pose_q.row + 4'd1;
      end
      default: begin
        in_b = pose_q.col != 4'd0;
        tc   = pose_q.col - 4'd1;
      end
    endcase
    legal = is_adv && in_b && !walls_q[nh];
  end

  always_comb begin
    state_d    = state_q;
    pose_d     = pose_q;
    done_d     = done_q;
    coll_d     = coll_q;
    steps_d    = steps_q;
    dead_d     = dead_q;
    load_walls = 1'b0;
    if (start) begin
      state_d    = ST_RUN;
      pose_d.col = 4'(START_C);
      pose_d.row = 4'(START_R);
      pose_d.hd  = HD_N;
      done_d     = 1'b0;
      coll_d     = 1'b0;
      steps_d    = 16'h0;
      dead_d     = 4'h0;
      load_walls = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (is_ut) begin
        pose_d.hd = pose_q.hd + 2'd2;
        if (dead_q != 4'hF)
          dead_d = dead_q + 4'd1;
      end else if (legal) begin
        pose_d.col = tc;
        pose_d.row = tr;
        pose_d.hd  = nh;
        load_walls = 1'b1;
        if (steps_q != 16'hFFFF)
          steps_d = steps_q + 16'd1;
        if (tc == 4'(EXIT_C) &&
            tr == 4'(EXIT_R)) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end else if (is_adv) begin
        coll_d  = 1'b1;
        state_d = ST_ERROR;
      end
    end
  end

  always_comb begin
    walls_d   = load_walls ? rd_data : walls_q;
    sens_d[1] = walls_d[pose_d.hd];
    sens_d[2] = walls_d[2'(pose_d.hd + 2'd3)];
    sens_d[0] = walls_d[2'(pose_d.hd + 2'd1)];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      pose_q.col <= 4'(START_C);
      pose_q.row <= 4'(START_R);
      pose_q.hd  <= HD_N;
      walls_q    <= 4'h0;
      sens_q     <= 3'b000;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
      steps_q    <= 16'h0;
      dead_q     <= 4'h0;
    end else begin
      state_q <= state_d;
      pose_q  <= pose_d;
      walls_q <= walls_d;
      sens_q  <= sens_d;
      done_q  <= done_d;
      coll_q  <= coll_d;
      steps_q <= steps_d;
      dead_q  <= dead_d;
    end
  end

  assign left          = sens_q[2];
  assign mid           = sens_q[1];
  assign right         = sens_q[0];
  assign pos_col       = pose_q.col;
  assign pos_row       = pose_q.row;
  assign heading       = pose_q.hd;
  assign done          = done_q;
  assign collision     = coll_q;
  assign step_count    = steps_q;
  assign deadend_count = dead_q;

endmodule

// File: tb/tb_t2c_maze_world.sv
// Self-checking bench for t2c_maze_world.
// Directed scenarios plus random runs against a rule-level model.
module tb_t2c_maze_world;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [2:0]  move;
  logic        left, mid, right;
  logic [3:0]  pos_col, pos_row;
  logic [1:0]  heading;
  logic        done, collision;
  logic [15:0] step_count;
  logic [3:0]  deadend_count;

  t2c_maze_world dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .move          (move),
    .left          (left),
    .mid           (mid),
    .right         (right),
    .pos_col       (pos_col),
    .pos_row       (pos_row),
    .heading       (heading),
    .done          (done),
    .collision     (collision),
    .step_count    (step_count),
    .deadend_count (deadend_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: mode 0 LOAD, 1 RUN, 2 DONE, 3 ERROR
  int mmap [81];
  int m_mode, m_c, m_r, m_h;
  int m_l, m_m, m_rt;
  int m_done, m_coll, m_steps, m_dead;

  function automatic void m_sense();
    int w;
    w    = mmap[m_r * 9 + m_c];
    m_m  = (w >> m_h) & 1;
    m_l  = (w >> ((m_h + 3) % 4)) & 1;
    m_rt = (w >> ((m_h + 1) % 4)) & 1;
  endfunction

  function automatic void m_reset();
    m_mode = 0; m_c = 4; m_r = 8; m_h = 0;
    m_l = 0; m_m = 0; m_rt = 0;
    m_done = 0; m_coll = 0;
    m_steps = 0; m_dead = 0;
  endfunction

  function automatic void m_edge();
    int was_load, mv, nh, tc, tr, w;
    if (!rst_n) begin
      m_reset();
      return;
    end
    was_load = (m_mode == 0);
    mv = int'(move);
    if (start) begin
      m_mode = 1; m_c = 4; m_r = 8; m_h = 0;
      m_done = 0; m_coll = 0;
      m_steps = 0; m_dead = 0;
      m_sense();
    end else if (m_mode == 1) begin
      if (mv == 4) begin
        m_h = (m_h + 2) % 4;
        if (m_dead < 15) m_dead++;
        m_sense();
      end else if (mv >= 1 && mv <= 3) begin
        nh = (mv == 1) ? m_h :
             (mv == 2) ? (m_h + 3) % 4 :
                         (m_h + 1) % 4;
        tc = m_c; tr = m_r;
        if (nh == 0) tr--;
        if (nh == 1) tc++;
        if (nh == 2) tr++;
        if (nh == 3) tc--;
        w = mmap[m_r * 9 + m_c];
        if (((w >> nh) & 1) == 0 &&
            tc >= 0 && tc < 9 &&
            tr >= 0 && tr < 9) begin
          m_c = tc; m_r = tr; m_h = nh;
          if (m_steps < 65535) m_steps++;
          m_sense();
          if (tc == 4 && tr == 0) begin
            m_done = 1; m_mode = 2;
          end
        end else begin
          m_coll = 1; m_mode = 3;
        end
      end
    end
    if (was_load && wr_en && wr_addr < 81)
      mmap[wr_addr] = int'(wr_data);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pos_col", 32'(pos_col), 32'(m_c));
    chk("pos_row", 32'(pos_row), 32'(m_r));
    chk("heading", 32'(heading), 32'(m_h));
    chk("left", 32'(left), 32'(m_l));
    chk("mid", 32'(mid), 32'(m_m));
    chk("right", 32'(right), 32'(m_rt));
    chk("done", 32'(done), 32'(m_done));
    chk("collision", 32'(collision), 32'(m_coll));
    chk("step_count", 32'(step_count), 32'(m_steps));
    chk("deadend", 32'(deadend_count), 32'(m_dead));
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
    chk_all();
  endtask

  task automatic drive(input logic st,
                       input logic we,
                       input int a,
                       input int d,
                       input int mv);
    start   = st;
    wr_en   = we;
    wr_addr = 7'(a);
    wr_data = 4'(d);
    move    = 3'(mv);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int d;
    rst_n = 1'b0; start = 0; wr_en = 0;
    wr_addr = 0; wr_data = 0; move = 0;
    for (int i = 0; i < 81; i++) mmap[i] = 0;
    m_reset();

    // 1: reset state, move ignored in LOAD
    do_reset();
    drive(0, 0, 0, 0, 0);
    chk("rst_col", 32'(pos_col), 32'd4);
    chk("rst_row", 32'(pos_row), 32'd8);
    chk("rst_sens", 32'({left, mid, right}), 32'd0);
    drive(0, 0, 0, 0, 1);
    chk("load_move", 32'(pos_row), 32'd8);

    // 2: straight corridor in col 4
    for (int a = 0; a < 81; a++)
      drive(0, 1, a, (a % 9 == 4) ? 4'hA : 4'hF, 0);
    drive(1, 0, 0, 0, 0);
    chk("c_sens0", 32'({left, mid, right}), 32'd5);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 1);
      chk("c_row", 32'(pos_row), 32'(7 - i));
      chk("c_sens", 32'({left, mid, right}), 32'd5);
    end
    chk("c_done", 32'(done), 32'd1);
    chk("c_steps", 32'(step_count), 32'd8);
    drive(0, 0, 0, 0, 1);
    chk("c_frozen", 32'(pos_row), 32'd0);

    // 3: collision from closed start cell
    do_reset();
    drive(0, 1, 76, 4'hB, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("col_flag", 32'(collision), 32'd1);
    chk("col_row", 32'(pos_row), 32'd8);
    chk("col_steps", 32'(step_count), 32'd0);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    chk("col_clr", 32'(collision), 32'd0);

    // 4: U_TURN in dead end and saturation
    drive(0, 0, 0, 0, 4);
    chk("ut_hd", 32'(heading), 32'd2);
    chk("ut_sens", 32'({left, mid, right}), 32'd5);
    chk("ut_cnt", 32'(deadend_count), 32'd1);
    for (int i = 0; i < 15; i++)
      drive(0, 0, 0, 0, 4);
    chk("ut_sat", 32'(deadend_count), 32'd15);

    // 5: LEFT then RIGHT
    do_reset();
    drive(0, 1, 76, 4'h4, 0);
    drive(0, 1, 75, 4'hC, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 2);
    chk("lt_hd", 32'(heading), 32'd3);
    chk("lt_col", 32'(pos_col), 32'd3);
    drive(0, 0, 0, 0, 3);
    chk("rt_hd", 32'(heading), 32'd0);
    chk("rt_row", 32'(pos_row), 32'd7);

    // 6: start beats move; reset mid-run keeps map
    do_reset();
    drive(0, 1, 76, 4'hA, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    chk("sm_row", 32'(pos_row), 32'd8);
    chk("sm_steps", 32'(step_count), 32'd0);
    drive(0, 0, 0, 0, 1);
    do_reset();
    chk("mr_row", 32'(pos_row), 32'd8);
    chk("mr_sens", 32'({left, mid, right}), 32'd0);
    drive(1, 0, 0, 0, 0);
    chk("mr_keep", 32'({left, mid, right}), 32'd5);

    // start and write in one cycle: sensors pre-write
    do_reset();
    drive(1, 1, 76, 4'h0, 0);
    chk("sw_sens", 32'({left, mid, right}), 32'd5);
    do_reset();
    drive(1, 0, 0, 0, 0);
    chk("sw_post", 32'({left, mid, right}), 32'd0);

    // random runs
    for (int k = 0; k < 4; k++) begin
      do_reset();
      for (int a = 0; a < 81; a++) begin
        d = int'($urandom & $urandom) & 15;
        drive(0, 1, a, d, 0);
      end
      for (int i = 0; i < 10; i++)
        drive(0, 1, 81 + int'($urandom_range(0, 46)),
              int'($urandom_range(0, 15)), 0);
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
        rst_n = ($urandom_range(0, 199) != 0);
        drive($urandom_range(0, 24) == 0,
              $urandom_range(0, 3) == 0,
              int'($urandom_range(0, 127)),
              int'($urandom_range(0, 15)),
              ($urandom_range(0, 1) == 1) ? 1 :
              int'($urandom_range(0, 7)));
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
